// File: rtl/lorenz_step_ctrl_if.sv
// Downstream sample channel of the Lorenz step controller: one x/y/z state per
// valid/ready handshake towards the plotter / HPS FIFO.
interface lorenz_step_ctrl_if #(
  parameter int W = 27
) ();
  logic signed [W-1:0] sample_x;
  logic signed [W-1:0] sample_y;
  logic signed [W-1:0] sample_z;
  logic                sample_valid;
  logic                sample_ready;

  modport master (
    output sample_x, sample_y, sample_z, sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_x, sample_y, sample_z, sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/lorenz_step_ctrl.sv
// Step sequencer for the Euler-step Lorenz datapath: latches the run constants,
// loads the initial conditions, paces integrator updates and hands each new state downstream.
module lorenz_step_ctrl #(
  parameter int W     = 27,
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic signed [W-1:0] cfg_sigma,
  input  logic signed [W-1:0] cfg_rho,
  input  logic signed [W-1:0] cfg_beta,
  input  logic signed [W-1:0] cfg_dt,
  input  logic signed [W-1:0] cfg_x0,
  input  logic signed [W-1:0] cfg_y0,
  input  logic signed [W-1:0] cfg_z0,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [CNT_W-1:0]    cfg_steps,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic signed [W-1:0] z_in,
  output logic signed [W-1:0] sigma,
  output logic signed [W-1:0] rho,
  output logic signed [W-1:0] beta,
  output logic signed [W-1:0] dt,
  output logic signed [W-1:0] x0,
  output logic signed [W-1:0] y0,
  output logic signed [W-1:0] z0,
  output logic                integ_init,
  output logic                integ_en,
  lorenz_step_ctrl_if.master  sample,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    step_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN, STEP, CAPT, WAIT, DONE
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    cfg_div_q;
  logic [CNT_W-1:0]    cfg_steps_q;
  logic signed [W-1:0] sample_x_q;
  logic signed [W-1:0] sample_y_q;
  logic signed [W-1:0] sample_z_q;
  logic                sample_valid_q;
  logic [CNT_W-1:0]    count_next;

  assign count_next = step_count + CNT_W'(1);

  // stop overrides everything, including a same-cycle start; only stop may drop
  // sample_valid without an accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      div_cnt        <= '0;
      cfg_div_q      <= '0;
      cfg_steps_q    <= '0;
      sigma          <= '0;
      rho            <= '0;
      beta           <= '0;
      dt             <= '0;
      x0             <= '0;
      y0             <= '0;
      z0             <= '0;
      sample_x_q     <= '0;
      sample_y_q     <= '0;
      sample_z_q     <= '0;
      sample_valid_q <= 1'b0;
      done           <= 1'b0;
      step_count     <= '0;
    end else if (stop) begin
      state          <= IDLE;
      sample_valid_q <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sigma       <= cfg_sigma;
            rho         <= cfg_rho;
            beta        <= cfg_beta;
            dt          <= cfg_dt;
            x0          <= cfg_x0;
            y0          <= cfg_y0;
            z0          <= cfg_z0;
            cfg_div_q   <= cfg_div;
            cfg_steps_q <= cfg_steps;
            step_count  <= '0;
            done        <= 1'b0;
            state       <= LOAD;
          end
        end
        LOAD: begin
          div_cnt <= cfg_div_q;
          state   <= RUN;
        end
        RUN: begin
          if (!pause) begin
            if (div_cnt == '0) state <= STEP;
            else               div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        STEP: state <= CAPT;
        // integrators already hold the post-step values here
        CAPT: begin
          sample_x_q     <= x_in;
          sample_y_q     <= y_in;
          sample_z_q     <= z_in;
          sample_valid_q <= 1'b1;
          state          <= WAIT;
        end
        WAIT: begin
          if (sample_valid_q && sample.sample_ready) begin
            sample_valid_q <= 1'b0;
            step_count     <= count_next;
            if (cfg_steps_q != '0 && count_next == cfg_steps_q) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              div_cnt <= cfg_div_q;
              state   <= RUN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign integ_init = (state == LOAD);
  assign integ_en   = (state == STEP);
  assign busy       = (state != IDLE) && (state != DONE);

  assign sample.sample_x     = sample_x_q;
  assign sample.sample_y     = sample_y_q;
  assign sample.sample_z     = sample_z_q;
  assign sample.sample_valid = sample_valid_q;

endmodule
